alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_issue.sv | 173 +++++++++++++++++
 tb/tb_alu_issue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command encodings used by the issue stage and the ALU itself.
// ALU_NOP is the idle command presented whenever no operation is executing.
package alu_pkg;
  localparam logic [4:0] ALU_NOP                            = 5'd0;
  localparam logic [4:0] ALU_ADD                            = 5'd1;
  localparam logic [4:0] ALU_SUB                            = 5'd2;
  localparam logic [4:0] ALU_AND                            = 5'd3;
  localparam logic [4:0] ALU_OR                             = 5'd4;
  localparam logic [4:0] ALU_XOR                            = 5'd5;
  localparam logic [4:0] ALU_NOR                            = 5'd6;
  localparam logic [4:0] ALU_COMP_LT                        = 5'd7;
  localparam logic [4:0] ALU_UNSIGNED_SHIFT_LEFT_SH_AMOUNT  = 5'd8;
  localparam logic [4:0] ALU_UNSIGNED_SHIFT_RIGHT_SH_AMOUNT = 5'd9;
  localparam logic [4:0] ALU_SIGNED_SHIFT_RIGHT_SH_AMOUNT   = 5'd10;
  localparam logic [4:0] ALU_UNSIGNED_SHIFT_LEFT            = 5'd11;
  localparam logic [4:0] ALU_UNSIGNED_SHIFT_RIGHT           = 5'd12;
  localparam logic [4:0] ALU_MULT                           = 5'd13;
  localparam logic [4:0] ALU_DIV                            = 5'd14;
  localparam logic [4:0] ALU_LUI                            = 5'd15;
endpackage

// File: rtl/alu_issue.sv
// MIPS R/I issue stage: decode, operand read, ALU command, writeback; ALU_OVF_TRAP_EN enables overflow trap.
// Latency: handshake edge N -> wb_en in cycle N+3; one instruction per 4 cycles.
// Backpressure: inst_ready only in IDLE; source holds inst_valid/inst until accepted.
module alu_issue
  import alu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [4:0]  alu_opt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t      state, state_nxt;
  logic [31:0] inst_q;
  logic [4:0]  dest_q;
  logic [5:0]  opcode, funct;
  logic [31:0] imm_s, imm_z;
  logic        dec_legal;
  logic [4:0]  dec_opt, dec_dest, dec_shamt;
  logic [31:0] dec_a, dec_b;

  assign opcode  = inst_q[31:26];
  assign funct   = inst_q[5:0];
  assign imm_s   = {{16{inst_q[15]}}, inst_q[15:0]};
  assign imm_z   = {16'h0000, inst_q[15:0]};
  assign rs_addr = inst_q[25:21];
  assign rt_addr = inst_q[20:16];

  always_comb begin
    dec_legal = 1'b1;
    dec_opt   = ALU_NOP;
    dec_a     = rs_data;
    dec_b     = rt_data;
    dec_dest  = inst_q[15:11];
    dec_shamt = inst_q[10:6];
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21: dec_opt = ALU_ADD;
        6'h22, 6'h23: dec_opt = ALU_SUB;
        6'h24:        dec_opt = ALU_AND;
        6'h25:        dec_opt = ALU_OR;
        6'h26:        dec_opt = ALU_XOR;
        6'h27:        dec_opt = ALU_NOR;
        6'h2A:        dec_opt = ALU_COMP_LT;
        6'h00:        dec_opt = ALU_UNSIGNED_SHIFT_LEFT_SH_AMOUNT;
        6'h02:        dec_opt = ALU_UNSIGNED_SHIFT_RIGHT_SH_AMOUNT;
        6'h03:        dec_opt = ALU_SIGNED_SHIFT_RIGHT_SH_AMOUNT;
        6'h04:        dec_opt = ALU_UNSIGNED_SHIFT_LEFT;
        6'h06:        dec_opt = ALU_UNSIGNED_SHIFT_RIGHT;
        6'h18:        dec_opt = ALU_MULT;
        6'h1A:        dec_opt = ALU_DIV;
        default:      dec_legal = 1'b0;
      endcase
    end else begin
      // I-type: the shamt field is immediate bits, so present no shift amount.
      dec_dest  = inst_q[20:16];
      dec_shamt = 5'd0;
      case (opcode)
        6'h08, 6'h09: begin dec_opt = ALU_ADD;     dec_b = imm_s; end
        6'h0A:        begin dec_opt = ALU_COMP_LT; dec_b = imm_s; end
        6'h0C:        begin dec_opt = ALU_AND;     dec_b = imm_z; end
        6'h0D:        begin dec_opt = ALU_OR;      dec_b = imm_z; end
        6'h0E:        begin dec_opt = ALU_XOR;     dec_b = imm_z; end
        6'h0F:        begin dec_opt = ALU_LUI;     dec_b = imm_z; dec_a = 32'h0; end
        default:      dec_legal = 1'b0;
      endcase
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic dec_trap, trap_q, ovf_r;
  assign dec_trap = (opcode == 6'h00) ? (funct == 6'h20 || funct == 6'h22) : (opcode == 6'h08);
  assign ovf      = ovf_r;
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
  assign ovf          = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    case (state)
      IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_nxt = READ;
      end
      READ:    state_nxt = dec_legal ? EXEC : IDLE;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inst_q    <= 32'h0;
      dest_q    <= 5'd0;
      alu_opt   <= ALU_NOP;
      alu_a     <= 32'h0;
      alu_b     <= 32'h0;
      alu_shamt <= 5'd0;
      wb_en     <= 1'b0;
      wb_addr   <= 5'd0;
      wb_data   <= 32'h0;
      illegal   <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      trap_q    <= 1'b0;
      ovf_r     <= 1'b0;
`endif
    end else begin
      // Command and pulse outputs are single-cycle unless re-asserted below.
      alu_opt <= ALU_NOP;
      wb_en   <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_OVF_TRAP_EN
      ovf_r   <= 1'b0;
`endif
      case (state)
        IDLE: if (inst_valid) inst_q <= inst;
        READ: begin
          if (dec_legal) begin
            alu_opt   <= dec_opt;
            alu_a     <= dec_a;
            alu_b     <= dec_b;
            alu_shamt <= dec_shamt;
            dest_q    <= dec_dest;
`ifdef ALU_OVF_TRAP_EN
            trap_q    <= dec_trap;
`endif
          end else begin
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          wb_data <= alu_out;
          wb_addr <= dest_q;
`ifdef ALU_OVF_TRAP_EN
          if (trap_q && alu_carry) ovf_r <= 1'b1;
          else                     wb_en <= (dest_q != 5'd0);
`else
          wb_en   <= (dest_q != 5'd0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed MIPS words, behavioural ALU and register file.
// Define ALU_OVF_TRAP_EN for both RTL and bench to exercise the overflow trap.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [4:0]  alu_opt, alu_shamt;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_carry;
  logic        wb_en, illegal, ovf;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  alu_issue dut (
    .clock(clock), .reset_n(reset_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .alu_opt(alu_opt), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal), .ovf(ovf)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] rf [32];
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  // Reference ALU: carry reports signed overflow for add/sub.
  always_comb begin
    alu_out   = 32'h0;
    alu_carry = 1'b0;
    case (alu_opt)
      ALU_ADD: begin
        alu_out   = alu_a + alu_b;
        alu_carry = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_SUB: begin
        alu_out   = alu_a - alu_b;
        alu_carry = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      ALU_AND:     alu_out = alu_a & alu_b;
      ALU_OR:      alu_out = alu_a | alu_b;
      ALU_XOR:     alu_out = alu_a ^ alu_b;
      ALU_NOR:     alu_out = ~(alu_a | alu_b);
      ALU_COMP_LT: alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
      ALU_UNSIGNED_SHIFT_LEFT_SH_AMOUNT:  alu_out = alu_b << alu_shamt;
      ALU_UNSIGNED_SHIFT_RIGHT_SH_AMOUNT: alu_out = alu_b >> alu_shamt;
      ALU_SIGNED_SHIFT_RIGHT_SH_AMOUNT:   alu_out = $signed(alu_b) >>> alu_shamt;
      ALU_UNSIGNED_SHIFT_LEFT:  alu_out = alu_b << alu_a[4:0];
      ALU_UNSIGNED_SHIFT_RIGHT: alu_out = alu_b >> alu_a[4:0];
      ALU_MULT:    alu_out = alu_a * alu_b;
      ALU_DIV:     alu_out = (alu_b == 32'h0) ? 32'hFFFF_FFFF : alu_a / alu_b;
      ALU_LUI:     alu_out = {alu_b[15:0], 16'h0000};
      default:     alu_out = 32'h0;
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  localparam int K_WB  = 1;
  localparam int K_ILL = 2;
  localparam int K_OVF = 3;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   m_k;

  // Monitor: every writeback/exception pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (wb_en || illegal || ovf) begin
      m_k = wb_en ? K_WB : (illegal ? K_ILL : K_OVF);
      if (sb.size() == 0) begin
        chk("spurious_event", 32'(m_k), 32'd0);
      end else begin
        m_e = sb.pop_front();
        chk("event_kind", 32'(m_k), 32'(m_e.kind));
        chk("event_cycle", 32'(cyc), 32'(m_e.due));
        if (m_e.kind == K_WB) begin
          chk("wb_addr", 32'(wb_addr), 32'(m_e.addr));
          chk("wb_data", wb_data, m_e.data);
        end
      end
    end
  end

  // Holds inst_valid until accepted; hs is the cycle count seen in the READ cycle.
  task automatic issue(input logic [31:0] w, output int hs);
    logic r;
    inst       = w;
    inst_valid = 1'b1;
    hs         = -1;
    for (int i = 0; i < 20; i++) begin
      r = inst_ready;
      @(posedge clock);
      if (r) begin
        @(negedge clock);
        hs = cyc;
        break;
      end
      @(negedge clock);
    end
    if (hs < 0) chk("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_wb(input int hs, input logic [4:0] a, input logic [31:0] d);
    sb.push_back('{kind: K_WB, addr: a, data: d, due: hs + 2});
  endtask

  // Called in the READ cycle; walks EXEC, WB and back to IDLE.
  task automatic exec_chk(input logic [4:0] opt, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
    @(negedge clock);
    chk("exec_alu_opt", 32'(alu_opt), 32'(opt));
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_shamt", 32'(alu_shamt), 32'(sh));
    @(negedge clock);
    chk("wb_alu_opt_idle", 32'(alu_opt), 32'(ALU_NOP));
    chk("wb_ready_low", 32'(inst_ready), 32'd0);
    @(negedge clock);
    chk("idle_ready", 32'(inst_ready), 32'd1);
  endtask

  int hs, h1, h2, rel;

  initial begin
    reset_n    = 1'b0;
    inst_valid = 1'b0;
    inst       = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[5]  = 32'h0000_000B;
    rf[7]  = 32'h0000_0007;
    rf[8]  = 32'h7FFF_FFFF;
    rf[9]  = 32'hFFFF_FFFF;
    rf[10] = 32'hFFFF_FFFE;
    repeat (3) @(negedge clock);

    chk("rst_inst_ready", 32'(inst_ready), 32'd1);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_alu_opt", 32'(alu_opt), 32'(ALU_NOP));
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);

    reset_n = 1'b1;
    rel     = cyc;

    // add rd=3, rs=5, rt=7: 0xB + 0x7
    issue({6'h00, 5'd5, 5'd7, 5'd3, 5'd0, 6'h20}, hs);
    inst_valid = 1'b0;
    chk("first_accept_cycle", 32'(hs), 32'(rel + 1));
    chk("read_rs_addr", 32'(rs_addr), 32'd5);
    chk("read_rt_addr", 32'(rt_addr), 32'd7);
    expect_wb(hs, 5'd3, 32'h0000_0012);
    exec_chk(ALU_ADD, 32'h0000_000B, 32'h0000_0007, 5'd0);

    // addi rt=2, rs=8 (0x7FFFFFFF), imm=1
    issue({6'h08, 5'd8, 5'd2, 16'h0001}, hs);
    inst_valid = 1'b0;
`ifdef ALU_OVF_TRAP_EN
    sb.push_back('{kind: K_OVF, addr: 5'd0, data: 32'h0, due: hs + 2});
`else
    expect_wb(hs, 5'd2, 32'h8000_0000);
`endif
    exec_chk(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);

    // andi rt=4, rs=9, imm=0x8000 (zero-extended)
    issue({6'h0C, 5'd9, 5'd4, 16'h8000}, hs);
    inst_valid = 1'b0;
    expect_wb(hs, 5'd4, 32'h0000_8000);
    exec_chk(ALU_AND, 32'hFFFF_FFFF, 32'h0000_8000, 5'd0);

    // slti rt=6, rs=10 (-2), imm=0xFFFF (-1)
    issue({6'h0A, 5'd10, 5'd6, 16'hFFFF}, hs);
    inst_valid = 1'b0;
    expect_wb(hs, 5'd6, 32'h0000_0001);
    exec_chk(ALU_COMP_LT, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5'd0);

    // lui rt=13, imm=0x1234: a forced to 0
    issue({6'h0F, 5'd5, 5'd13, 16'h1234}, hs);
    inst_valid = 1'b0;
    expect_wb(hs, 5'd13, 32'h1234_0000);
    exec_chk(ALU_LUI, 32'h0, 32'h0000_1234, 5'd0);

    // srl rd=14, rt=9, shamt=4
    issue({6'h00, 5'd0, 5'd9, 5'd14, 5'd4, 6'h02}, hs);
    inst_valid = 1'b0;
    expect_wb(hs, 5'd14, 32'h0FFF_FFFF);
    exec_chk(ALU_UNSIGNED_SHIFT_RIGHT_SH_AMOUNT, 32'h0, 32'hFFFF_FFFF, 5'd4);

    // div rd=16, rs=5, rt=0: ALU result passes through untouched
    issue({6'h00, 5'd5, 5'd0, 5'd16, 5'd0, 6'h1A}, hs);
    inst_valid = 1'b0;
    expect_wb(hs, 5'd16, 32'hFFFF_FFFF);
    exec_chk(ALU_DIV, 32'h0000_000B, 32'h0, 5'd0);

    // opcode 0x3F: illegal pulse with IDLE in the same cycle
    issue({6'h3F, 26'h0}, hs);
    inst_valid = 1'b0;
    sb.push_back('{kind: K_ILL, addr: 5'd0, data: 32'h0, due: hs + 1});
    @(negedge clock);
    chk("illegal_ready", 32'(inst_ready), 32'd1);
    chk("illegal_no_exec", 32'(alu_opt), 32'(ALU_NOP));

    // sll rd=0: full sequence, no writeback
    issue({6'h00, 5'd0, 5'd7, 5'd0, 5'd4, 6'h00}, hs);
    inst_valid = 1'b0;
    exec_chk(ALU_UNSIGNED_SHIFT_LEFT_SH_AMOUNT, 32'h0, 32'h0000_0007, 5'd4);

    // back-to-back sub rd=11 then or rd=12 with inst_valid held high
    issue({6'h00, 5'd5, 5'd7, 5'd11, 5'd0, 6'h22}, h1);
    expect_wb(h1, 5'd11, 32'h0000_0004);
    issue({6'h00, 5'd5, 5'd7, 5'd12, 5'd0, 6'h25}, h2);
    inst_valid = 1'b0;
    chk("b2b_spacing", 32'(h2 - h1), 32'd4);
    expect_wb(h2, 5'd12, 32'h0000_000F);
    repeat (3) @(negedge clock);

    // xor rd=17 aborted by reset in EXEC
    issue({6'h00, 5'd5, 5'd7, 5'd17, 5'd0, 6'h26}, hs);
    inst_valid = 1'b0;
    @(negedge clock);
    chk("pre_abort_alu_opt", 32'(alu_opt), 32'(ALU_XOR));
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(inst_ready), 32'd1);
    chk("abort_alu_opt", 32'(alu_opt), 32'(ALU_NOP));
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    // xor rd=18 after the abort completes normally
    issue({6'h00, 5'd5, 5'd7, 5'd18, 5'd0, 6'h26}, hs);
    inst_valid = 1'b0;
    expect_wb(hs, 5'd18, 32'h0000_000C);
    exec_chk(ALU_XOR, 32'h0000_000B, 32'h0000_0007, 5'd0);

    repeat (4) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
